// File: rtl/hq_dh_sequencer.sv
// rtl/hq_dh_sequencer.sv - buffers one Hq matrix and streams it to Dh_cal in 16 bursts
//
// Purpose: holds a 4x32 complex Hq matrix (loaded column-major) and, on start,
//   feeds Dh_cal one burst per Dh (two columns, 8 samples), waiting for the
//   Dh_cal result between bursts. Completion is pulsed on done; a missing
//   result aborts the run with the sticky err flag.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   wr_en/wr_real/wr_im - load strobe and sample (written at wr_ptr)
//   start             - begin a run (needs a full buffer, IDLE)
//   Dh_result_valid   - result flag from Dh_cal (rising edge accepted in WAIT)
//   loaded, busy      - buffer full / run in progress
//   Dh_en, out_real, out_im - registered sample stream to Dh_cal
//   q_idx             - Dh index being fed or awaited
//   done, err         - completion pulse / sticky timeout flag
module hq_dh_sequencer #(
  parameter int Q       = 8,
  parameter int N       = 16,
  parameter int HQ_ROWS = 4,
  parameter int HQ_COLS = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic signed [N-1:0] wr_real,
  input  logic signed [N-1:0] wr_im,
  input  logic                start,
  input  logic                Dh_result_valid,
  output logic                loaded,
  output logic                busy,
  output logic                Dh_en,
  output logic signed [N-1:0] out_real,
  output logic signed [N-1:0] out_im,
  output logic [3:0]          q_idx,
  output logic                done,
  output logic                err
);

  localparam int DEPTH  = HQ_ROWS * HQ_COLS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BURST  = 2 * HQ_ROWS;
  localparam int K_W    = $clog2(BURST);
  localparam int LAST_Q = HQ_COLS / 2 - 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  // Q is a fixed-point annotation only; the samples pass through untouched.
  if (((HQ_COLS % 2) != 0) || (HQ_COLS / 2 > 16) || (Q >= N)) begin : g_param_check
    $error("hq_dh_sequencer: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_DONE
  } state_t;

  logic signed [N-1:0] r_mem_re [DEPTH];
  logic signed [N-1:0] r_mem_im [DEPTH];

  state_t              r_state,    w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_ptr,   w_wr_ptr_nxt;
  logic                r_loaded,   w_loaded_nxt;
  logic                r_busy,     w_busy_nxt;
  logic                r_err,      w_err_nxt;
  logic                r_done,     w_done_nxt;
  logic                r_dh_en,    w_dh_en_nxt;
  logic [3:0]          r_q,        w_q_nxt;
  logic [K_W-1:0]      r_k,        w_k_nxt;
  logic [CNT_W-1:0]    r_wait_cnt, w_wait_cnt_nxt;
  logic signed [N-1:0] r_out_real, w_out_real_nxt;
  logic signed [N-1:0] r_out_im,   w_out_im_nxt;
  logic                r_valid_d;

  logic                w_accept;
  logic                w_wr_fire;
  logic                w_rd_en;
  logic [ADDR_W-1:0]   w_rd_addr;

  // Burst q covers columns 2q and 2q+1, which are contiguous in column-major order.
  function automatic logic [ADDR_W-1:0] f_addr(input logic [3:0] q, input logic [K_W-1:0] k);
    return ADDR_W'(q) * ADDR_W'(BURST) + ADDR_W'(k);
  endfunction

  // Only a fresh rising edge counts, so a level left high from earlier is ignored.
  assign w_accept  = (r_state == S_WAIT) && Dh_result_valid && !r_valid_d;
  assign w_wr_fire = (r_state == S_IDLE) && !r_loaded && wr_en;

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_loaded_nxt   = r_loaded;
    w_busy_nxt     = r_busy;
    w_err_nxt      = r_err;
    w_q_nxt        = r_q;
    w_k_nxt        = r_k;
    w_wait_cnt_nxt = r_wait_cnt;
    w_dh_en_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_rd_en        = 1'b0;
    w_rd_addr      = '0;

    case (r_state)
      S_IDLE: begin
        // start is only honoured with a full buffer, and wr_en is blocked then,
        // so start always wins over a simultaneous write.
        if (start && r_loaded) begin
          w_state_nxt = S_FEED;
          w_err_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
          w_q_nxt     = '0;
          w_k_nxt     = '0;
          w_dh_en_nxt = 1'b1;
          w_rd_en     = 1'b1;
          w_rd_addr   = f_addr(4'd0, '0);
        end else if (w_wr_fire) begin
          if (r_wr_ptr == ADDR_W'(DEPTH - 1)) begin
            w_wr_ptr_nxt = '0;
            w_loaded_nxt = 1'b1;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
          end
        end
      end

      S_FEED: begin
        // r_k is the index of the sample currently on the outputs.
        if (r_k == K_W'(BURST - 1)) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = '0;
        end else begin
          w_k_nxt     = r_k + K_W'(1);
          w_dh_en_nxt = 1'b1;
          w_rd_en     = 1'b1;
          w_rd_addr   = f_addr(r_q, r_k + K_W'(1));
        end
      end

      S_WAIT: begin
        // Accept is checked before the timeout so a result on the last allowed cycle wins.
        if (w_accept) begin
          if (r_q == 4'(LAST_Q)) begin
            w_state_nxt  = S_DONE;
            w_done_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_loaded_nxt = 1'b0;
            w_wr_ptr_nxt = '0;
          end else begin
            w_state_nxt = S_FEED;
            w_q_nxt     = r_q + 4'd1;
            w_k_nxt     = '0;
            w_dh_en_nxt = 1'b1;
            w_rd_en     = 1'b1;
            w_rd_addr   = f_addr(r_q + 4'd1, '0);
          end
        end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs hold their last sample whenever no new one is read.
  assign w_out_real_nxt = w_rd_en ? r_mem_re[w_rd_addr] : r_out_real;
  assign w_out_im_nxt   = w_rd_en ? r_mem_im[w_rd_addr] : r_out_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_loaded   <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_dh_en    <= 1'b0;
      r_q        <= '0;
      r_k        <= '0;
      r_wait_cnt <= '0;
      r_out_real <= '0;
      r_out_im   <= '0;
      r_valid_d  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_loaded   <= w_loaded_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
      r_done     <= w_done_nxt;
      r_dh_en    <= w_dh_en_nxt;
      r_q        <= w_q_nxt;
      r_k        <= w_k_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_out_real <= w_out_real_nxt;
      r_out_im   <= w_out_im_nxt;
      r_valid_d  <= Dh_result_valid;
    end
  end

  // Buffer has no reset: contents survive rst and are simply overwritten by the next load.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_fire) begin
      r_mem_re[r_wr_ptr] <= wr_real;
      r_mem_im[r_wr_ptr] <= wr_im;
    end
  end

  assign loaded   = r_loaded;
  assign busy     = r_busy;
  assign Dh_en    = r_dh_en;
  assign out_real = r_out_real;
  assign out_im   = r_out_im;
  assign q_idx    = r_q;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_hq_dh_sequencer.sv
// tb/tb_hq_dh_sequencer.sv - directed self-checking bench for hq_dh_sequencer
module tb_hq_dh_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wr_en = 1'b0;
  logic signed [15:0] wr_real = '0;
  logic signed [15:0] wr_im = '0;
  logic               start = 1'b0;
  logic               Dh_result_valid;
  logic               loaded, busy, Dh_en, done, err;
  logic signed [15:0] out_real, out_im;
  logic [3:0]         q_idx;

  logic model_auto  = 1'b0;
  logic model_valid = 1'b0;
  logic man_valid   = 1'b0;
  int   model_en_cnt = 0;
  int   model_dly    = 0;

  int n_tests = 0;
  int n_fail  = 0;

  int cap_re [128];
  int cap_im [128];
  int cap_q  [128];

  assign Dh_result_valid = model_auto ? model_valid : man_valid;

  hq_dh_sequencer #(
    .Q(8), .N(16), .HQ_ROWS(4), .HQ_COLS(32), .TIMEOUT(64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_real         (wr_real),
    .wr_im           (wr_im),
    .start           (start),
    .Dh_result_valid (Dh_result_valid),
    .loaded          (loaded),
    .busy            (busy),
    .Dh_en           (Dh_en),
    .out_real        (out_real),
    .out_im          (out_im),
    .q_idx           (q_idx),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  // Dh_cal stand-in: one-cycle valid pulse 3 cycles after every 8th Dh_en.
  always @(negedge clk) begin
    model_valid = 1'b0;
    if (!model_auto || rst) begin
      model_en_cnt = 0;
      model_dly    = 0;
    end else begin
      if (model_dly != 0) begin
        model_dly = model_dly - 1;
        if (model_dly == 0) model_valid = 1'b1;
      end
      if (Dh_en) begin
        model_en_cnt = model_en_cnt + 1;
        if (model_en_cnt == 8) begin
          model_en_cnt = 0;
          model_dly    = 3;
        end
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 128; i++) begin
      wr_en   = 1'b1;
      wr_real = 16'(i);
      wr_im   = 16'(-i);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  // Called on the first Dh_en cycle of a run; captures the stream until done.
  task automatic run_full(output int n_en, output int n_done, output int d_busy, output int d_loaded);
    n_en = 0; n_done = 0; d_busy = -1; d_loaded = -1;
    for (int c = 0; c < 400 && n_done == 0; c++) begin
      if (Dh_en) begin
        if (n_en < 128) begin
          cap_re[n_en] = out_real;
          cap_im[n_en] = out_im;
          cap_q[n_en]  = q_idx;
        end
        n_en++;
      end
      if (done) begin
        n_done++;
        d_busy   = busy;
        d_loaded = loaded;
      end
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      if (done) n_done++;
      if (Dh_en) n_en++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_en, n_done, d_busy, d_loaded, cnt, got;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_loaded", loaded, 0);
    check("rst_busy", busy, 0);
    check("rst_dh_en", Dh_en, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_q_idx", q_idx, 0);
    check("rst_out_real", out_real, 0);
    rst = 1'b0;
    @(negedge clk);

    // Start with empty buffer is ignored
    do_start();
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (Dh_en || busy) cnt++;
      @(negedge clk);
    end
    check("noload_activity", cnt, 0);

    // Load 128 samples; loaded rises after the 128th write
    for (int i = 0; i < 128; i++) begin
      wr_en   = 1'b1;
      wr_real = 16'(i);
      wr_im   = 16'(-i);
      if (i == 127) check("loaded_before_last", loaded, 0);
      @(negedge clk);
    end
    check("loaded_after_last", loaded, 1);
    wr_real = 16'sd999;
    wr_im   = 16'sd999;
    @(negedge clk);
    wr_en = 1'b0;

    // Held-high valid never accepted -> timeout; wr_en during FEED ignored
    model_auto = 1'b0;
    do_start();
    cnt = 0;
    for (int n = 1; n <= 73; n++) begin
      if (n == 3) man_valid = 1'b1;
      if (n == 4) begin
        wr_en = 1'b1; wr_real = 16'sd555; wr_im = 16'sd555;
      end
      if (n == 6) wr_en = 1'b0;
      if (Dh_en) cnt++;
      if (n == 72) begin
        check("to_err_before", err, 0);
        check("to_busy_before", busy, 1);
        check("wait_hold_real", out_real, 7);
      end
      if (n == 73) begin
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        check("to_dh_en", Dh_en, 0);
        check("to_done", done, 0);
        check("to_loaded", loaded, 1);
      end
      if (n < 73) @(negedge clk);
    end
    check("to_burst_len", cnt, 8);
    man_valid = 1'b0;
    @(negedge clk);

    // Retry with pulsed model: full run
    model_auto = 1'b1;
    do_start();
    check("retry_err_clr", err, 0);
    check("retry_first_en", Dh_en, 1);
    run_full(n_en, n_done, d_busy, d_loaded);
    check("run_n_en", n_en, 128);
    check("run_n_done", n_done, 1);
    check("run_done_busy", d_busy, 0);
    check("run_done_loaded", d_loaded, 0);
    for (int k = 0; k < 8; k++) begin
      check("q0_re", cap_re[k], k);
      check("q5_re", cap_re[40 + k], 40 + k);
      check("q5_im", cap_im[40 + k], -(40 + k));
    end
    for (int q = 0; q < 16; q++) check("q_idx_seq", cap_q[q * 8 + 7], q);
    check("last_re", cap_re[127], 127);
    check("end_busy", busy, 0);
    check("end_loaded", loaded, 0);

    // rst on the 4th Dh_en of q=2
    load_all();
    check("reload1_loaded", loaded, 1);
    do_start();
    cnt = 0; got = 0;
    for (int c = 0; c < 200 && got == 0; c++) begin
      if (Dh_en && q_idx == 4'd2) begin
        cnt++;
        if (cnt == 4) begin
          rst = 1'b1;
          got = 1;
        end
      end
      @(negedge clk);
    end
    check("rst_hit", got, 1);
    check("midrst_dh_en", Dh_en, 0);
    check("midrst_q_idx", q_idx, 0);
    check("midrst_busy", busy, 0);
    check("midrst_loaded", loaded, 0);
    check("midrst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    load_all();
    do_start();
    run_full(n_en, n_done, d_busy, d_loaded);
    check("rerun_n_en", n_en, 128);
    check("rerun_n_done", n_done, 1);
    check("rerun_q2_re", cap_re[19], 19);
    check("rerun_q2_im", cap_im[19], -19);

    // Valid edge on WAIT cycle 64 is accepted
    load_all();
    model_auto = 1'b0;
    man_valid  = 1'b0;
    do_start();
    for (int n = 1; n <= 73; n++) begin
      if (n == 72) man_valid = 1'b1;
      if (n == 73) begin
        check("edge64_err", err, 0);
        check("edge64_q_idx", q_idx, 1);
        check("edge64_dh_en", Dh_en, 1);
        check("edge64_real", out_real, 8);
        check("edge64_busy", busy, 1);
      end
      if (n < 73) @(negedge clk);
    end
    man_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hq_dh_sequencer.md
Name: hq_dh_sequencer

Overview:
- Upstream feeder for Dh_cal.
- Buffers one complete 4x32 complex Hq matrix (Q8.8) loaded column-major.
- On start, streams it to Dh_cal as 16 bursts. Burst q carries column 2q rows 0..3, then column 2q+1 rows 0..3. It then waits for Dh_cal's result before sending the next burst.
- Signals completion after Dh_15, and aborts with an error if Dh_cal never answers.

Parameters:
- Q, 8, fractional bits (pass-through, documentation only)
- N, 16, sample width
- HQ_ROWS, 4, rows of Hq
- HQ_COLS, 32, columns of Hq (must be even)
- TIMEOUT, 64, max cycles in WAIT before abort

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  load strobe, one sample per cycle
- wr_real  in  N  signed real part of load sample
- wr_im  in  N  signed imag part of load sample
- start  in  1  begin a 16-Dh run
- Dh_result_valid  in  1  result flag from Dh_cal
- loaded  out  1  matrix buffer full (128 samples written)
- busy  out  1  run in progress
- Dh_en  out  1  sample-valid strobe to Dh_cal
- out_real  out  N  signed real sample to Dh_cal
- out_im  out  N  signed imag sample to Dh_cal
- q_idx  out  4  index of Dh currently being fed or awaited
- done  out  1  one-cycle pulse after the result for q=15
- err  out  1  sticky timeout flag, cleared by rst or next accepted start

Behaviour:
- Storage: two arrays (real, imag) of HQ_ROWS*HQ_COLS=128 entries. Address = col*HQ_ROWS + row.
- Reset: all outputs 0, wr_ptr=0, state IDLE. Buffer contents are not cleared.
- Load:
  - In IDLE with loaded=0, wr_en writes to wr_ptr and increments it.
  - The write that fills address 127 sets loaded=1 the next cycle.
  - wr_en is ignored when loaded=1 or in any non-IDLE state.
- Start: accepted only in IDLE with loaded=1. Otherwise ignored, with no flag.
- Accepted start: clears err, sets busy=1, q_idx=0, k=0, enters FEED.
- FEED:
  - Outputs are registered. Dh_en=1 for exactly 8 consecutive cycles.
  - out_real/out_im = mem[q*8+k], with k=0..7.
  - First Dh_en rises on the cycle after the start edge.
  - After k=7, Dh_en=0, out_real/out_im hold their last value, and the state goes to WAIT.
- WAIT:
  - Rising-edge detect on Dh_result_valid: accept when valid=1 and its previous-cycle value=0. A level held high from before WAIT is not accepted.
  - On accept with q<15: q_idx++, k=0, back to FEED. Next Dh_en starts the cycle after accept.
  - On accept with q=15: go to DONE.
  - Dh_result_valid outside WAIT is ignored.
- DONE (1 cycle): done=1, busy=0, loaded=0, wr_ptr=0, then IDLE. The next run requires a fresh load; the buffer is overwritten.
- Timeout:
  - WAIT cycle counter resets on entry.
  - At TIMEOUT cycles without accept: err=1, busy=0, Dh_en=0, state IDLE.
  - loaded stays 1, so start may retry from q=0.
  - done is not asserted.
- Simultaneous events:
  - Start together with wr_en in IDLE while loaded=1: start wins, wr_en ignored.
  - Accept on the same cycle the timeout counter hits TIMEOUT: accept wins.
- rst mid-run: immediate return to reset values on the next edge. No done pulse; loaded=0.
- Latency per Dh: 8 feed cycles + Dh_cal latency + 1 accept cycle.

Test Plan:
- Load 128 samples with real=addr, im=-addr. loaded rises the cycle after the 128th write. A 129th wr_en leaves mem[0] unchanged.
- Start with a model Dh_cal returning a valid pulse 3 cycles after the 8th Dh_en:
  - q=0 streams real 0..7.
  - q=5 streams real 40..47, im -40..-47.
  - q_idx steps 0..15.
  - done pulses once after the 16th accept; busy and loaded drop.
- Start with loaded=0, and wr_en during FEED: both ignored. No Dh_en appears, and buffer contents are unchanged.
- Model holds Dh_result_valid high continuously from before q=0 ends: no accept, and after 64 cycles err=1 and busy=0. A pulsed retry then completes with err cleared.
- Assert rst on the 4th Dh_en of q=2: the next cycle shows Dh_en=0, q_idx=0, busy=0, loaded=0. Reload and rerun complete normally.
- Model raises valid on exactly cycle 64 of WAIT: accepted, err stays 0, and q advances.
